// File: rtl/x87_decode_queue.sv
// x87 front-end decoder: assembles ESC opcode pairs from a byte stream, decodes them
// into FPU command/index entries and buffers them in a first-word-fall-through FIFO.
module x87_decode_queue #(
    parameter int DEPTH        = 4,
    parameter int EXT_MEM      = 1,
    parameter int FNINIT_ALIAS = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic [7:0]                   byte_in,
    input  logic                         byte_valid,
    output logic                         byte_ready,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [5:0]                   out_cmd,
    output logic [2:0]                   out_idx,
    output logic                         out_illegal,
    output logic [7:0]                   out_op1,
    output logic [7:0]                   out_modrm,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         busy
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int EW = 26;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    typedef enum logic {IDLE = 1'b0, HAVE_OP1 = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [7:0]      op1_q;
    logic [EW-1:0]   mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   cnt_q;
    logic            accept, push, pop;
    logic [EW-1:0]   push_data, head;
    logic [9:0]      dec;

    // Returns {illegal, cmd[5:0], idx[2:0]} for an ESC pair.
    function automatic logic [9:0] decode_pair(input logic [7:0] op1, input logic [7:0] m);
        logic       mem;
        logic [2:0] rg;
        logic [2:0] rm;
        logic [5:0] cmd;
        logic [2:0] idx;
        logic       ill;
        mem = (m[7:6] != 2'b11);
        rg  = m[5:3];
        rm  = m[2:0];
        cmd = 6'd0;
        idx = 3'd0;
        ill = 1'b0;
        if (op1 == 8'hDF && m == 8'hE0) begin
            cmd = 6'd1;
        end else if (m == 8'hE3 && (op1 == 8'hDB || (op1 == 8'hD9 && FNINIT_ALIAS != 0))) begin
            cmd = 6'd2;
        end else if ((op1 == 8'hDF || op1 == 8'hDB) && mem) begin
            idx = {2'b00, op1 == 8'hDB};
            case (rg)
                3'd0:    cmd = 6'd16;
                3'd2:    cmd = 6'd17;
                3'd3:    cmd = 6'd18;
                default: ill = 1'b1;
            endcase
        end else if (op1 == 8'hD9 && mem) begin
            case (rg)
                3'd5:    cmd = 6'd3;
                3'd7:    cmd = 6'd4;
                3'd0:    cmd = 6'd6;
                3'd3:    cmd = 6'd8;
                default: ill = 1'b1;
            endcase
        end else if (op1 == 8'hDD && mem) begin
            case (rg)
                3'd0:    cmd = 6'd7;
                3'd3:    cmd = 6'd9;
                default: ill = 1'b1;
            endcase
        end else if (op1 == 8'hD9) begin
            if (rg == 3'd0)      begin cmd = 6'd10; idx = rm;   end
            else if (rg == 3'd1) begin cmd = 6'd11; idx = rm;   end
            else if (m == 8'hFE) begin cmd = 6'd19; idx = 3'd0; end
            else if (m == 8'hFF) begin cmd = 6'd19; idx = 3'd1; end
            else if (m == 8'hF2) begin cmd = 6'd19; idx = 3'd2; end
            else ill = 1'b1;
        end else if (op1 == 8'hDD) begin
            if (rg == 3'd3) begin cmd = 6'd12; idx = rm; end
            else ill = 1'b1;
        end else if (op1 == 8'hD8 && !mem) begin
            idx = rm;
            case (rg)
                3'd0:    cmd = 6'd20;
                3'd1:    cmd = 6'd21;
                3'd2:    cmd = 6'd23;
                3'd3:    cmd = 6'd26;
                3'd4:    cmd = 6'd24;
                3'd5:    cmd = 6'd25;
                3'd6:    cmd = 6'd22;
                default: cmd = 6'd30;
            endcase
        end else if (op1 == 8'hDE && !mem) begin
            idx = rm;
            case (rg)
                3'd0:    cmd = 6'd27;
                3'd1:    cmd = 6'd28;
                3'd4:    cmd = 6'd13;
                3'd5:    cmd = 6'd14;
                3'd6:    cmd = 6'd29;
                3'd7:    cmd = 6'd15;
                default: ill = 1'b1;
            endcase
        end else if (EXT_MEM != 0 && mem && (op1 == 8'hD8 || op1 == 8'hDC)) begin
            cmd = (op1 == 8'hD8) ? 6'd32 : 6'd33;
            idx = rg;
        end else begin
            ill = 1'b1;
        end
        if (ill) begin
            cmd = 6'd0;
            idx = 3'd0;
        end
        return {ill, cmd, idx};
    endfunction

    // Handshake: no path from out_ready to byte_ready, so a full FIFO always refuses.
    assign byte_ready = !flush && (cnt_q != FULL_CNT);
    assign accept     = byte_valid && byte_ready;
    assign out_valid  = (cnt_q != '0);
    assign pop        = out_valid && out_ready && !flush;
    assign dec        = decode_pair(op1_q, byte_in);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        push      = 1'b0;
        push_data = '0;
        if (accept) begin
            case (state_q)
                IDLE: begin
                    if (byte_in[7:3] == 5'b11011) begin
                        state_d = HAVE_OP1;
                    end else if (byte_in == 8'h9B) begin
                        push      = 1'b1;
                        push_data = {6'd5, 3'd0, 1'b0, byte_in, 8'h00};
                    end else begin
                        push      = 1'b1;
                        push_data = {6'd0, 3'd0, 1'b1, byte_in, 8'h00};
                    end
                end
                default: begin
                    push      = 1'b1;
                    push_data = {dec[8:3], dec[2:0], dec[9], op1_q, byte_in};
                    state_d   = IDLE;
                end
            endcase
        end
        if (flush) state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (accept && state_q == IDLE) op1_q <= byte_in;
    end

    // FIFO storage is cleared on reset so the head reads as all-zero afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + PTR_ONE;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PTR_ONE;
            if (push && !pop)      cnt_q <= cnt_q + CNT_ONE;
            else if (!push && pop) cnt_q <= cnt_q - CNT_ONE;
        end
    end

    assign head        = mem_q[rd_ptr_q];
    assign out_cmd     = head[25:20];
    assign out_idx     = head[19:17];
    assign out_illegal = head[16];
    assign out_op1     = head[15:8];
    assign out_modrm   = head[7:0];
    assign count       = cnt_q;
    assign busy        = (state_q == HAVE_OP1);

endmodule

// File: tb/tb_x87_decode_queue.sv
// Randomized scoreboard bench for x87_decode_queue: a rule-level reference model
// predicts entries, occupancy and handshake signals; a monitor checks popped entries.
module tb_x87_decode_queue;

    localparam int DEPTH        = 4;
    localparam int EXT_MEM      = 1;
    localparam int FNINIT_ALIAS = 1;
    localparam int CW           = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [5:0] cmd;
        logic [2:0] idx;
        logic       ill;
        logic [7:0] op1;
        logic [7:0] modrm;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic [7:0]    byte_in = 8'h00;
    logic          byte_valid = 1'b0;
    logic          byte_ready;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [5:0]    out_cmd;
    logic [2:0]    out_idx;
    logic          out_illegal;
    logic [7:0]    out_op1;
    logic [7:0]    out_modrm;
    logic [CW-1:0] count;
    logic          busy;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t exp_q[$];
    int   mcnt = 0;
    bit   pend = 1'b0;
    logic [7:0] pend_op1 = 8'h00;
    bit   m_acc, m_pop, m_push;

    x87_decode_queue #(.DEPTH(DEPTH), .EXT_MEM(EXT_MEM), .FNINIT_ALIAS(FNINIT_ALIAS)) dut (
        .clk(clk), .rst(rst), .flush(flush), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_cmd(out_cmd), .out_idx(out_idx), .out_illegal(out_illegal),
        .out_op1(out_op1), .out_modrm(out_modrm), .count(count), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode written directly from the opcode rule list.
    function automatic exp_t ref_pair(input logic [7:0] op1, input logic [7:0] m);
        int   d8_tab[8] = '{20, 21, 23, 26, 24, 25, 22, 30};
        int   de_tab[8] = '{27, 28, -1, -1, 13, 14, 29, 15};
        int   rg = int'(m[5:3]);
        int   rm = int'(m[2:0]);
        bit   is_mem = (m < 8'hC0);
        int   c = -1;
        int   ix = 0;
        exp_t e;
        if (op1 == 8'hDF && m == 8'hE0) c = 1;
        else if (m == 8'hE3 && (op1 == 8'hDB || (op1 == 8'hD9 && FNINIT_ALIAS == 1))) c = 2;
        else if ((op1 == 8'hDF || op1 == 8'hDB) && is_mem && (rg == 0 || rg == 2 || rg == 3)) begin
            c = (rg == 0) ? 16 : 15 + rg;
            ix = (op1 == 8'hDB) ? 1 : 0;
        end
        else if (op1 == 8'hD9 && is_mem && rg == 5) c = 3;
        else if (op1 == 8'hD9 && is_mem && rg == 7) c = 4;
        else if (op1 == 8'hD9 && is_mem && rg == 0) c = 6;
        else if (op1 == 8'hD9 && is_mem && rg == 3) c = 8;
        else if (op1 == 8'hDD && is_mem && rg == 0) c = 7;
        else if (op1 == 8'hDD && is_mem && rg == 3) c = 9;
        else if (op1 == 8'hD9 && m >= 8'hC0 && m <= 8'hC7) begin c = 10; ix = rm; end
        else if (op1 == 8'hD9 && m >= 8'hC8 && m <= 8'hCF) begin c = 11; ix = rm; end
        else if (op1 == 8'hDD && m >= 8'hD8 && m <= 8'hDF) begin c = 12; ix = rm; end
        else if (op1 == 8'hD8 && !is_mem) begin c = d8_tab[rg]; ix = rm; end
        else if (op1 == 8'hDE && !is_mem && de_tab[rg] >= 0) begin c = de_tab[rg]; ix = rm; end
        else if (op1 == 8'hD9 && m == 8'hFE) begin c = 19; ix = 0; end
        else if (op1 == 8'hD9 && m == 8'hFF) begin c = 19; ix = 1; end
        else if (op1 == 8'hD9 && m == 8'hF2) begin c = 19; ix = 2; end
        else if (EXT_MEM == 1 && is_mem && op1 == 8'hD8) begin c = 32; ix = rg; end
        else if (EXT_MEM == 1 && is_mem && op1 == 8'hDC) begin c = 33; ix = rg; end
        e.op1   = op1;
        e.modrm = m;
        e.ill   = (c < 0);
        e.cmd   = (c < 0) ? 6'd0 : 6'(c);
        e.idx   = (c < 0) ? 3'd0 : 3'(ix);
        return e;
    endfunction

    // Reference model: handshake/occupancy checks and expected-entry generation.
    always @(negedge clk) begin
        if (rst) begin
            mcnt = 0;
            pend = 1'b0;
            exp_q.delete();
        end else begin
            check("count", 32'(count), 32'(mcnt));
            check("out_valid", 32'(out_valid), 32'(mcnt != 0));
            check("byte_ready", 32'(byte_ready), 32'(!flush && mcnt != DEPTH));
            check("busy", 32'(busy), 32'(pend));
            m_pop = (mcnt != 0) && out_ready && !flush;
            m_acc = byte_valid && !flush && (mcnt != DEPTH);
            m_push = 1'b0;
            if (flush) begin
                mcnt = 0;
                pend = 1'b0;
                exp_q.delete();
            end else begin
                if (m_acc) begin
                    if (pend) begin
                        exp_q.push_back(ref_pair(pend_op1, byte_in));
                        pend   = 1'b0;
                        m_push = 1'b1;
                    end else if (byte_in >= 8'hD8 && byte_in <= 8'hDF) begin
                        pend     = 1'b1;
                        pend_op1 = byte_in;
                    end else begin
                        exp_q.push_back('{cmd: (byte_in == 8'h9B) ? 6'd5 : 6'd0, idx: 3'd0,
                                          ill: (byte_in != 8'h9B), op1: byte_in, modrm: 8'h00});
                        m_push = 1'b1;
                    end
                end
                mcnt = mcnt + int'(m_push) - int'(m_pop);
            end
        end
    end

    // Monitor: compares every entry the DUT hands over.
    always @(negedge clk) begin
        if (!rst && !flush && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_entry: got %0h, expected none", {out_cmd, out_idx, out_illegal, out_op1, out_modrm});
            end else begin
                check("entry", 32'({out_cmd, out_idx, out_illegal, out_op1, out_modrm}), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic step(input bit v, input logic [7:0] b, input bit r, input bit f);
        byte_valid = v;
        byte_in    = b;
        out_ready  = r;
        flush      = f;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_cmd", 32'(out_cmd), 32'd0);
        check("rst_out_idx", 32'(out_idx), 32'd0);
        check("rst_out_illegal", 32'(out_illegal), 32'd0);
        check("rst_out_op1", 32'(out_op1), 32'd0);
        check("rst_out_modrm", 32'(out_modrm), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_byte_ready", 32'(byte_ready), 32'd1);
    endtask

    logic [7:0] specials[8] = '{8'hE0, 8'hE3, 8'hFE, 8'hFF, 8'hF2, 8'h45, 8'hC3, 8'hD9};

    initial begin
        @(posedge clk);
        #1;
        check_reset_outputs();
        rst = 1'b0;

        // Directed stream with a ready consumer.
        step(1, 8'hDF, 1, 0); step(1, 8'hE0, 1, 0);
        step(1, 8'hD9, 1, 0); step(1, 8'hC3, 1, 0);
        step(1, 8'h9B, 1, 0);
        step(1, 8'hD8, 1, 0); step(1, 8'h45, 1, 0);
        step(1, 8'hD9, 1, 0); step(1, 8'hE3, 1, 0);
        step(1, 8'h90, 1, 0);
        step(0, 8'h00, 1, 0); step(0, 8'h00, 1, 0);

        // Fill to full, then a single-cycle pop.
        for (int i = 0; i < 6; i++) step(1, 8'h9B, 0, 0);
        step(1, 8'h9B, 1, 0);
        step(1, 8'h9B, 0, 0);
        step(1, 8'h9B, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 8'h00, 1, 0);

        // Flush discards the pending op1.
        step(1, 8'hD9, 1, 0);
        step(1, 8'hC1, 1, 1);
        step(1, 8'hC1, 1, 0);
        step(1, 8'hC1, 1, 0);
        for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0);

        // Randomized traffic with varying consumer pressure.
        for (int blk = 0; blk < 4; blk++) begin
            for (int i = 0; i < 600; i++) begin
                int k;
                logic [7:0] b;
                k = $urandom_range(0, 9);
                if (k < 4)       b = 8'hD8 + 8'($urandom_range(0, 7));
                else if (k == 4) b = 8'h9B;
                else if (k < 7)  b = specials[$urandom_range(0, 7)];
                else             b = 8'($urandom_range(0, 255));
                step($urandom_range(0, 9) < 8, b, $urandom_range(0, 3) < blk + 1,
                     $urandom_range(0, 99) == 0);
            end
        end
        for (int i = 0; i < 8; i++) step(0, 8'h00, 1, 0);
        check("drain_empty", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset mid-pair with entries queued.
        step(1, 8'h9B, 0, 0);
        step(1, 8'h9B, 0, 0);
        step(1, 8'hD9, 0, 0);
        byte_valid = 1'b0;
        check("pre_rst_busy", 32'(busy), 32'd1);
        check("pre_rst_count", 32'(count), 32'd2);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs();
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1, 8'hDE, 1, 0); step(1, 8'hF9, 1, 0);
        step(1, 8'hDB, 1, 0); step(1, 8'h10, 1, 0);
        for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0);
        check("final_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
